// File: rtl/irs3_pkg.sv
// Shared types and widths for the IRS3 readout controller and its address stepper.
package irs3_pkg;

    localparam int IRS3_DAT_W = 12;
    localparam int IRS3_SMP_W = 6;
    localparam int IRS3_CH_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CONV,
        ST_SETTLE,
        ST_CAPTURE,
        ST_PUSH,
        ST_DONE,
        ST_ABORT
    } irs3_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/irs3_addr_stepper.sv
// Channel/sample address counter for the IRS3 readout: steps sample-major, wraps into
// the next channel, flags the final (NCH-1, NSMP-1) address.
module irs3_addr_stepper
    import irs3_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int NSMP = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear,
    input  logic                  step,
    output logic [IRS3_CH_W-1:0]  ch,
    output logic [IRS3_SMP_W-1:0] smp,
    output logic                  last
);

    localparam logic [IRS3_CH_W-1:0]  CH_LAST  = IRS3_CH_W'(NCH - 1);
    localparam logic [IRS3_SMP_W-1:0] SMP_LAST = IRS3_SMP_W'(NSMP - 1);

    assign last = (ch == CH_LAST) && (smp == SMP_LAST);

    // Stepping past the last address is refused so the counters never wrap on their own.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ch  <= '0;
            smp <= '0;
        end else if (clear) begin
            ch  <= '0;
            smp <= '0;
        end else if (step && !last) begin
            if (smp == SMP_LAST) begin
                smp <= '0;
                ch  <= ch + IRS3_CH_W'(1);
            end else begin
                smp <= smp + IRS3_SMP_W'(1);
            end
        end
    end

endmodule

// File: rtl/irs3_readout_ctrl.sv
// IRS3 digitize-and-readout sequencer: CLR, Wilkinson conversion, then CH/SMP scan streamed out.
// Define IRS3_READOUT_TESTPAT_EN to replace captured DAT with an address-derived test pattern.
module irs3_readout_ctrl
    import irs3_pkg::*;
#(
    parameter int CLR_CYCLES    = 4,
    parameter int CONV_CYCLES   = 4400,
    parameter int SETTLE_CYCLES = 3,
    parameter int NCH           = 8,
    parameter int NSMP          = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  irs_clr_o,
    output logic                  irs_start_o,
    output logic                  irs_ramp_o,
    output logic                  irs_doe_o,
    output logic [IRS3_SMP_W-1:0] irs_smp_o,
    output logic [IRS3_CH_W-1:0]  irs_ch_o,
    input  logic [IRS3_DAT_W-1:0] irs_dat_i,
    output logic [IRS3_DAT_W-1:0] dat_o,
    output logic [IRS3_CH_W-1:0]  dat_ch_o,
    output logic [IRS3_SMP_W-1:0] dat_smp_o,
    output logic                  dat_last_o,
    output logic                  dat_valid_o,
    input  logic                  dat_ready_i
);

    localparam int CNT_W = $clog2(max3(CLR_CYCLES, CONV_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    irs3_state_t            state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   addr_clr, addr_step;
    logic [IRS3_CH_W-1:0]   ch;
    logic [IRS3_SMP_W-1:0]  smp;
    logic                   last;
    logic [IRS3_DAT_W-1:0]  capture_word;

    irs3_addr_stepper #(
        .NCH  (NCH),
        .NSMP (NSMP)
    ) u_stepper (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (addr_clr),
        .step    (addr_step),
        .ch      (ch),
        .smp     (smp),
        .last    (last)
    );

    assign irs_ch_o  = ch;
    assign irs_smp_o = smp;

`ifdef IRS3_READOUT_TESTPAT_EN
    assign capture_word = {ch, smp, 3'b101};
`else
    assign capture_word = irs_dat_i;
`endif

    // The phase counter restarts at zero on every state entry; abort overrides everything,
    // including a handshake completing in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_clr  = 1'b0;
        addr_step = 1'b0;
        if (abort_i && (state != ST_IDLE)) begin
            state_nxt = ST_ABORT;
            cnt_nxt   = '0;
            addr_clr  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        state_nxt = ST_CLEAR;
                        cnt_nxt   = '0;
                        addr_clr  = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == CLR_LAST) begin
                        state_nxt = ST_CONV;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_CONV: begin
                    if (cnt == CONV_LAST) begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = ST_CAPTURE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: state_nxt = ST_PUSH;
                ST_PUSH: begin
                    if (dat_ready_i) begin
                        if (last) begin
                            state_nxt = ST_DONE;
                            addr_clr  = 1'b1;
                        end else begin
                            state_nxt = ST_SETTLE;
                            addr_step = 1'b1;
                        end
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                ST_ABORT: begin
                    if (cnt == CLR_LAST) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pin outputs are decoded from the next state into flops so the IRS3 sees clean edges.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            irs_clr_o   <= 1'b0;
            irs_start_o <= 1'b0;
            irs_ramp_o  <= 1'b0;
            irs_doe_o   <= 1'b0;
            dat_valid_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            busy_o      <= (state_nxt != ST_IDLE);
            done_o      <= (state_nxt == ST_DONE);
            irs_clr_o   <= (state_nxt == ST_CLEAR) || (state_nxt == ST_ABORT);
            irs_start_o <= (state_nxt == ST_CONV);
            irs_ramp_o  <= (state_nxt == ST_CONV);
            irs_doe_o   <= (state_nxt == ST_SETTLE) || (state_nxt == ST_CAPTURE) ||
                           (state_nxt == ST_PUSH);
            dat_valid_o <= (state_nxt == ST_PUSH);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_o      <= '0;
            dat_ch_o   <= '0;
            dat_smp_o  <= '0;
            dat_last_o <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            dat_o      <= capture_word;
            dat_ch_o   <= ch;
            dat_smp_o  <= smp;
            dat_last_o <= last;
        end
    end

endmodule

// File: tb/tb_irs3_readout_ctrl.sv
// Self-checking bench for irs3_readout_ctrl: timestamp-based reference model of the readout
// timeline, randomized DAT waveform and back-pressure, plus literal checks of key timings.
`timescale 1ns/1ps
module tb_irs3_readout_ctrl;

    localparam int CLR        = 4;
    localparam int CONV       = 4400;
    localparam int SETTLE     = 3;
    localparam int NCH        = 8;
    localparam int NSMP       = 64;
    localparam int NBEATS     = NCH * NSMP;
    localparam int WAIT_LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic        busy_o, done_o, irs_clr_o, irs_start_o, irs_ramp_o, irs_doe_o;
    logic [5:0]  irs_smp_o;
    logic [2:0]  irs_ch_o;
    logic [11:0] irs_dat;
    logic [11:0] dat_o;
    logic [2:0]  dat_ch_o;
    logic [5:0]  dat_smp_o;
    logic        dat_last_o, dat_valid_o;

    logic [11:0] wave [NBEATS];
    logic [11:0] junk = 12'h000;
    bit          stall_mode = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dut_beats = 0;
    int dut_dones = 0;

    // Reference model: event timestamps and beat index, no state encoding
    bit m_active = 1'b0, m_aborting = 1'b0, m_done = 1'b0;
    int m_ev_start = 0, m_seg_start = 0, m_abort_start = 0, m_beat = 0;

    always #5 clk = ~clk;

    // IRS3 stand-in: DAT reflects the addressed cell while DOE is high, junk otherwise
    assign irs_dat = irs_doe_o ? wave[{irs_ch_o, irs_smp_o}] : junk;

    irs3_readout_ctrl #(
        .CLR_CYCLES    (CLR),
        .CONV_CYCLES   (CONV),
        .SETTLE_CYCLES (SETTLE),
        .NCH           (NCH),
        .NSMP          (NSMP)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .abort_i     (abort),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .irs_clr_o   (irs_clr_o),
        .irs_start_o (irs_start_o),
        .irs_ramp_o  (irs_ramp_o),
        .irs_doe_o   (irs_doe_o),
        .irs_smp_o   (irs_smp_o),
        .irs_ch_o    (irs_ch_o),
        .irs_dat_i   (irs_dat),
        .dat_o       (dat_o),
        .dat_ch_o    (dat_ch_o),
        .dat_smp_o   (dat_smp_o),
        .dat_last_o  (dat_last_o),
        .dat_valid_o (dat_valid_o),
        .dat_ready_i (ready)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
            if (failures >= 50) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy_o, done_o, irs_clr_o, irs_start_o, irs_ramp_o, irs_doe_o, irs_smp_o,
                    irs_ch_o, dat_o, dat_ch_o, dat_smp_o, dat_last_o, dat_valid_o});
    endfunction

    function automatic bit m_valid_at(input int m);
        return m_active && (m >= m_seg_start) && ((m - m_seg_start) >= SETTLE + 1);
    endfunction

    task automatic model_step();
        bit prev_valid, was_done;
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0; m_aborting = 1'b0; m_done = 1'b0; m_beat = 0;
            return;
        end
        prev_valid = m_valid_at(cyc - 1);
        was_done   = m_done;
        m_done     = 1'b0;
        if (abort && (m_active || m_aborting || was_done)) begin
            m_active = 1'b0; m_aborting = 1'b1; m_abort_start = cyc;
        end else if (m_active) begin
            if (prev_valid && ready) begin
                if (m_beat == NBEATS - 1) begin
                    m_active = 1'b0; m_done = 1'b1;
                end else begin
                    m_beat++; m_seg_start = cyc;
                end
            end
        end else if (m_aborting) begin
            if (cyc - m_abort_start >= CLR) m_aborting = 1'b0;
        end else if (!was_done && req) begin
            m_active = 1'b1; m_ev_start = cyc; m_seg_start = cyc + CLR + CONV; m_beat = 0;
        end
    endtask

    task automatic compareCycle();
        int          m;
        bit          rd, cl, cv, vl;
        logic [2:0]  ech;
        logic [5:0]  esmp;
        logic [11:0] edat;
        m = cyc;
        if (!rst_n) begin
            checkOutput("reset_outputs", all_outs(), 64'h0);
            return;
        end
        rd   = m_active && (m >= m_seg_start);
        cl   = (m_active && (m - m_ev_start < CLR)) || m_aborting;
        cv   = m_active && (m - m_ev_start >= CLR) && (m - m_ev_start < CLR + CONV);
        vl   = m_valid_at(m);
        ech  = m_active ? 3'(m_beat / NSMP) : 3'd0;
        esmp = m_active ? 6'(m_beat % NSMP) : 6'd0;
        checkOutput("ctl_pins",
            64'({busy_o, done_o, irs_clr_o, irs_start_o, irs_ramp_o, irs_doe_o, dat_valid_o,
                 irs_ch_o, irs_smp_o}),
            64'({(m_active || m_aborting || m_done), m_done, cl, cv, cv, rd, vl, ech, esmp}));
        if (vl) begin
`ifdef IRS3_READOUT_TESTPAT_EN
            edat = {ech, esmp, 3'b101};
            if (m_beat == 5 * NSMP + 33) checkOutput("testpat_b0d", 64'(dat_o), 64'hB0D);
`else
            edat = wave[m_beat];
`endif
            checkOutput("beat_data", 64'({dat_o, dat_ch_o, dat_smp_o, dat_last_o}),
                        64'({edat, ech, esmp, (m_beat == NBEATS - 1)}));
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst_n && dat_valid_o && ready && !abort) dut_beats++;
        if (rst_n && done_o) dut_dones++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compareCycle();
    end

    initial forever begin
        @(posedge clk);
        #1;
        ready = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        junk  = 12'($urandom);
    end

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit a);
        req   = r;
        abort = a;
    endtask

    task automatic waitUntilIdle(input string name);
        int n = 0;
        while (busy_o && n < WAIT_LIMIT) begin tick(); n++; end
        checkOutput(name, 64'(busy_o), 64'h0);
    endtask

    initial begin
        int lat, gap, n, b0, d0, clr_len;
        for (int i = 0; i < NBEATS; i++) wave[i] = 12'($urandom);
        #2;
        checkOutput("reset_state", all_outs(), 64'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full readout with ready held high; the IDLE cycle that samples req_i counts as cycle 1
        tick();
        b0 = dut_beats; d0 = dut_dones;
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        lat = 1;
        while (!dat_valid_o && lat < WAIT_LIMIT) begin lat++; tick(); end
        checkOutput("latency", 64'(lat), 64'd4409);
        waitUntilIdle("full_run_idle");
        checkOutput("full_run_beats", 64'(dut_beats - b0), 64'd512);
        checkOutput("full_run_dones", 64'(dut_dones - d0), 64'd1);

        // Random back-pressure with req_i held high so a second event follows immediately
        for (int i = 0; i < NBEATS; i++) wave[i] = 12'($urandom);
        repeat (2) tick();
        b0 = dut_beats; d0 = dut_dones;
        stall_mode = 1'b1;
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (!done_o && n < WAIT_LIMIT) begin tick(); n++; end
        checkOutput("stall_done_seen", 64'(done_o), 64'h1);
        stall_mode = 1'b0;
        checkOutput("stall_beats", 64'(dut_beats - b0), 64'd512);
        tick();
        gap = 0;
        while (!busy_o && gap < 10) begin gap++; tick(); end
        checkOutput("restart_gap", 64'(gap), 64'd1);
        checkOutput("stall_dones", 64'(dut_dones - d0), 64'd1);
        applyStimulus(1'b0, 1'b0);

        // Abort the back-to-back event at ch=2, smp=10 while a handshake would complete
        n = 0;
        while (!(dat_valid_o && irs_ch_o == 3'd2 && irs_smp_o == 6'd10) && n < WAIT_LIMIT) begin
            tick(); n++;
        end
        checkOutput("abort_point_seen", 64'({dat_valid_o, irs_ch_o, irs_smp_o}), 64'({1'b1, 3'd2, 6'd10}));
        applyStimulus(1'b0, 1'b1);
        b0 = dut_beats; d0 = dut_dones;
        tick();
        applyStimulus(1'b0, 1'b0);
        clr_len = 0;
        while (irs_clr_o && clr_len < 20) begin clr_len++; tick(); end
        checkOutput("abort_clr_cycles", 64'(clr_len), 64'd4);
        checkOutput("abort_busy_low", 64'(busy_o), 64'h0);
        repeat (20) tick();
        checkOutput("abort_no_beats", 64'(dut_beats - b0), 64'd0);
        checkOutput("abort_no_done", 64'(dut_dones - d0), 64'd0);

        // Asynchronous reset in the middle of conversion, then a clean restart
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (!irs_start_o && n < 50) begin tick(); n++; end
        repeat (100) tick();
        checkOutput("conv_active", 64'({irs_start_o, irs_ramp_o}), 64'h3);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_mid_conv", all_outs(), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        b0 = dut_beats; d0 = dut_dones;
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_clear", 64'({irs_clr_o, busy_o, irs_start_o}), 64'b110);
        waitUntilIdle("restart_run_idle");
        checkOutput("restart_run_beats", 64'(dut_beats - b0), 64'd512);
        checkOutput("restart_run_dones", 64'(dut_dones - d0), 64'd1);

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
